cpu_alu: RTL and testbench
==========================

Name: cpu_alu

Overview:
- 32-bit integer ALU in the axis_cpu datapath, with one registered result stage and a valid/ack output handshake.
- Takes operands A and B and a 4-bit operation select. It produces a result word plus four comparison flags (set, eq, gt, ge) that the branch logic uses.
- The result and flags are captured together and held until the consumer acknowledges them.

Parameters:
- none (data width fixed at 32 bits, select width fixed at 4 bits)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- A  input  32  operand A
- B  input  32  operand B / shift amount
- ALU_sel  input  4  operation select
- ALU_en  input  1  request: compute on current A, B, ALU_sel
- ALU_ack  input  1  consumer accepts the held result
- ALU_out  output  32  registered result
- set  output  1  registered: (A & B) != 0
- eq  output  1  registered: A == B
- gt  output  1  registered: A > B, unsigned
- ge  output  1  registered: A >= B, unsigned
- ALU_vld  output  1  ALU_out and the flags hold an unconsumed result

Behaviour:
- Reset (rst=1 at a rising edge): ALU_out=0, set=eq=gt=ge=0, ALU_vld=0. Reset overrides ALU_en and ALU_ack in the same cycle.
- Operation encoding (all arithmetic modulo 2^32, operands unsigned):
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 MUL: low 32 bits of A*B
  - 3 reserved: 0
  - 4 OR: A|B
  - 5 AND: A&B
  - 6 LSH: A<<B; result 0 if B>=32
  - 7 RSH: logical A>>B; result 0 if B>=32
  - 8 NEG: 0-A
  - 9 reserved: 0
  - 10 XOR: A^B
  - 11-15 reserved: 0
- Flags are computed from A and B regardless of ALU_sel.
- accept = ALU_en && (!ALU_vld || ALU_ack).
- On accept: ALU_out and the flags load the values computed from this cycle's A, B, ALU_sel. ALU_vld=1 next cycle.
  - Latency: exactly one clock from accept to visible result.
- If ALU_ack && ALU_vld && !accept: ALU_vld=0 next cycle. ALU_out and the flags keep their last values.
- Otherwise all outputs hold.
  - A pending result (ALU_vld=1, no ack) is never overwritten. ALU_en is ignored until ack.
- Simultaneous ack and en while valid: the old result is consumed and the new one loaded in the same edge. ALU_vld stays 1 (back-to-back throughput of one op per cycle).
- ALU_ack while ALU_vld=0: no effect.
- A, B, ALU_sel need only be stable in the accept cycle. Later changes do not affect held outputs.
- Reset mid-operation discards any held result. No pending state survives reset.

Test Plan:
- Reset: assert rst with ALU_en=1, A=5, B=3 -> next cycle ALU_out=0, ALU_vld=0, all flags 0.
- Arithmetic:
  - A=7, B=5, sel=0, en=1 for one cycle -> next cycle ALU_out=12, vld=1, eq=0, gt=1, ge=1, set=1.
  - Then sel=1 with A=3, B=5 after ack -> ALU_out=4294967294, gt=0, ge=0.
- Logic/shift:
  - A=0xF0, B=0x0F, sel=5 -> ALU_out=0, set=0.
  - A=1, B=31, sel=6 -> 0x80000000.
  - A=1, B=32, sel=6 -> 0.
  - A=0x80000000, B=31, sel=7 -> 1.
  - A=5, sel=8 -> 4294967291.
- Hold/backpressure: result valid, ack=0, en=1 with new operands for 3 cycles -> ALU_out and flags unchanged, vld stays 1. Assert ack alone -> vld=0 next cycle, ALU_out retained.
- Back-to-back: vld=1, en=1 and ack=1 each cycle with A=B=9, sel=0, then A=9, B=10, sel=10 -> consecutive results 18 (eq=1, ge=1, gt=0) then 3 (eq=0, gt=0, ge=0); vld never drops.
- Reserved and multiply:
  - sel=3, 9 and 15 with A=10, B=2 -> ALU_out=0; flags still eq=0, gt=1, ge=1, set=1.
  - sel=2, A=0x10000, B=0x10000 -> 0.

Source files
------------

// File: rtl/cpu_alu_if.sv
// Operand/request and registered-result handshake bundle for the cpu_alu block.
interface cpu_alu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALU_sel;
    logic        ALU_en;
    logic        ALU_ack;
    logic [31:0] ALU_out;
    logic        set;
    logic        eq;
    logic        gt;
    logic        ge;
    logic        ALU_vld;

    // Requester side: supplies operands, requests and acknowledges.
    modport master (
        output A, B, ALU_sel, ALU_en, ALU_ack,
        input  ALU_out, set, eq, gt, ge, ALU_vld
    );

    // ALU side: consumes operands, presents the held result.
    modport slave (
        input  A, B, ALU_sel, ALU_en, ALU_ack,
        output ALU_out, set, eq, gt, ge, ALU_vld
    );
endinterface

// File: rtl/cpu_alu.sv
// 32-bit integer ALU with one registered result stage and a valid/ack hold handshake.
// Result and branch flags are captured together and held until acknowledged.
module cpu_alu (
    input  logic     clk,
    input  logic     rst,
    cpu_alu_if.slave bus
);

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpMul = 4'd2,
        OpOr  = 4'd4,
        OpAnd = 4'd5,
        OpLsh = 4'd6,
        OpRsh = 4'd7,
        OpNeg = 4'd8,
        OpXor = 4'd10
    } alu_op_e;

    logic [31:0] result_d;
    logic [31:0] result_q;
    logic        set_d, eq_d, gt_d, ge_d;
    logic        set_q, eq_q, gt_q, ge_q;
    logic        vld_q;
    logic        shift_oob;
    logic        accept;

    // A new op is taken only when nothing is pending or the pending result is consumed now.
    assign accept    = bus.ALU_en && (!vld_q || bus.ALU_ack);
    assign shift_oob = |bus.B[31:5];

    // Combinational result select; reserved encodings yield zero.
    always_comb begin
        result_d = '0;
        case (bus.ALU_sel)
            OpAdd:   result_d = bus.A + bus.B;
            OpSub:   result_d = bus.A - bus.B;
            OpMul:   result_d = bus.A * bus.B;
            OpOr:    result_d = bus.A | bus.B;
            OpAnd:   result_d = bus.A & bus.B;
            OpLsh:   result_d = shift_oob ? 32'd0 : (bus.A << bus.B[4:0]);
            OpRsh:   result_d = shift_oob ? 32'd0 : (bus.A >> bus.B[4:0]);
            OpNeg:   result_d = 32'd0 - bus.A;
            OpXor:   result_d = bus.A ^ bus.B;
            default: result_d = '0;
        endcase
    end

    // Branch flags depend only on the operands, never on the select.
    always_comb begin
        set_d = |(bus.A & bus.B);
        eq_d  = (bus.A == bus.B);
        gt_d  = (bus.A > bus.B);
        ge_d  = (bus.A >= bus.B);
    end

    // Result stage: load on accept, drop valid on a bare ack, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            set_q    <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
            ge_q     <= 1'b0;
            vld_q    <= 1'b0;
        end else if (accept) begin
            result_q <= result_d;
            set_q    <= set_d;
            eq_q     <= eq_d;
            gt_q     <= gt_d;
            ge_q     <= ge_d;
            vld_q    <= 1'b1;
        end else if (bus.ALU_ack && vld_q) begin
            vld_q    <= 1'b0;
        end
    end

    assign bus.ALU_out = result_q;
    assign bus.set     = set_q;
    assign bus.eq      = eq_q;
    assign bus.gt      = gt_q;
    assign bus.ge      = ge_q;
    assign bus.ALU_vld = vld_q;

endmodule

// File: tb/tb_cpu_alu.sv
// Directed-vector bench for cpu_alu with hand-computed expectations.
module tb_cpu_alu;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    cpu_alu_if bus ();

    cpu_alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic s, input logic e,
                               input logic g, input logic ge_exp);
        check({tag, ".set"}, {31'd0, bus.set}, {31'd0, s});
        check({tag, ".eq"},  {31'd0, bus.eq},  {31'd0, e});
        check({tag, ".gt"},  {31'd0, bus.gt},  {31'd0, g});
        check({tag, ".ge"},  {31'd0, bus.ge},  {31'd0, ge_exp});
    endtask

    // Issue one op with ack asserted alongside, so a pending result is consumed.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        bus.A       = a;
        bus.B       = b;
        bus.ALU_sel = sel;
        bus.ALU_en  = 1'b1;
        bus.ALU_ack = 1'b1;
        step();
        bus.ALU_en  = 1'b0;
        bus.ALU_ack = 1'b0;
    endtask

    typedef struct {
        string       tag;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[$];

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        bus.A       = 32'd5;
        bus.B       = 32'd3;
        bus.ALU_sel = 4'd0;
        bus.ALU_en  = 1'b1;
        bus.ALU_ack = 1'b0;
        rst         = 1'b1;

        // Reset wins over a concurrent request.
        step();
        check("rst.out", bus.ALU_out, 32'd0);
        check("rst.vld", {31'd0, bus.ALU_vld}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        bus.ALU_en = 1'b0;
        step();
        check("idle.vld", {31'd0, bus.ALU_vld}, 32'd0);

        // ADD, single-cycle request.
        bus.A = 32'd7; bus.B = 32'd5; bus.ALU_sel = 4'd0; bus.ALU_en = 1'b1;
        step();
        bus.ALU_en = 1'b0;
        bus.A = 32'd0; bus.B = 32'd0;
        check("add.out", bus.ALU_out, 32'd12);
        check("add.vld", {31'd0, bus.ALU_vld}, 32'd1);
        check_flags("add", 1'b1, 1'b0, 1'b1, 1'b1);

        // Bare ack consumes.
        bus.ALU_ack = 1'b1;
        step();
        bus.ALU_ack = 1'b0;
        check("ack.vld", {31'd0, bus.ALU_vld}, 32'd0);
        check("ack.out", bus.ALU_out, 32'd12);

        // SUB with wrap.
        bus.A = 32'd3; bus.B = 32'd5; bus.ALU_sel = 4'd1; bus.ALU_en = 1'b1;
        step();
        bus.ALU_en = 1'b0;
        check("sub.out", bus.ALU_out, 32'd4294967294);
        check_flags("sub", 1'b1, 1'b0, 1'b0, 1'b0);

        // Operation table, each op back-to-back with ack.
        vecs.push_back('{"and",  32'h0000_00F0, 32'h0000_000F, 4'd5,  32'd0});
        vecs.push_back('{"lsh31", 32'd1,        32'd31,        4'd6,  32'h8000_0000});
        vecs.push_back('{"lsh32", 32'd1,        32'd32,        4'd6,  32'd0});
        vecs.push_back('{"lshbig", 32'd1,       32'h0000_0100, 4'd6,  32'd0});
        vecs.push_back('{"lsh4", 32'h0000_00F1, 32'd4,         4'd6,  32'h0000_0F10});
        vecs.push_back('{"rsh31", 32'h8000_0000, 32'd31,       4'd7,  32'd1});
        vecs.push_back('{"rsh32", 32'h8000_0000, 32'd32,       4'd7,  32'd0});
        vecs.push_back('{"rsh4", 32'hF000_0000, 32'd4,         4'd7,  32'h0F00_0000});
        vecs.push_back('{"or",   32'h0000_00F0, 32'h0000_000F, 4'd4,  32'h0000_00FF});
        vecs.push_back('{"xor",  32'h0000_0FF0, 32'h0000_00FF, 4'd10, 32'h0000_0F0F});
        vecs.push_back('{"mul",  32'd6,         32'd7,         4'd2,  32'd42});
        vecs.push_back('{"mulov", 32'h0001_0000, 32'h0001_0000, 4'd2, 32'd0});
        vecs.push_back('{"mulhi", 32'h0001_0001, 32'h0001_0000, 4'd2, 32'h0001_0000});
        vecs.push_back('{"res3", 32'd10,        32'd2,         4'd3,  32'd0});
        vecs.push_back('{"res9", 32'd10,        32'd2,         4'd9,  32'd0});
        vecs.push_back('{"res15", 32'd10,       32'd2,         4'd15, 32'd0});
        vecs.push_back('{"neg",  32'd5,         32'd0,         4'd8,  32'd4294967291});
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel);
            check({vecs[i].tag, ".out"}, bus.ALU_out, vecs[i].res);
            check({vecs[i].tag, ".vld"}, {31'd0, bus.ALU_vld}, 32'd1);
            if (vecs[i].sel == 4'd3 || vecs[i].sel == 4'd9 || vecs[i].sel == 4'd15) begin
                check_flags(vecs[i].tag, 1'b1, 1'b0, 1'b1, 1'b1);
            end
        end
        check_flags("and.flags.after_neg", 1'b0, 1'b0, 1'b1, 1'b1);

        // Backpressure: held NEG result must survive new requests without ack.
        bus.A = 32'd100; bus.B = 32'd100; bus.ALU_sel = 4'd0;
        bus.ALU_en = 1'b1; bus.ALU_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check("hold.out", bus.ALU_out, 32'd4294967291);
            check("hold.vld", {31'd0, bus.ALU_vld}, 32'd1);
            check_flags("hold", 1'b0, 1'b0, 1'b1, 1'b1);
        end
        bus.ALU_en = 1'b0; bus.ALU_ack = 1'b1;
        step();
        bus.ALU_ack = 1'b0;
        check("hold.ack.vld", {31'd0, bus.ALU_vld}, 32'd0);
        check("hold.ack.out", bus.ALU_out, 32'd4294967291);
        step();
        check("ackidle.vld", {31'd0, bus.ALU_vld}, 32'd0);

        // Back-to-back with en and ack both high.
        bus.A = 32'd9; bus.B = 32'd9; bus.ALU_sel = 4'd0;
        bus.ALU_en = 1'b1; bus.ALU_ack = 1'b1;
        step();
        check("b2b1.out", bus.ALU_out, 32'd18);
        check("b2b1.vld", {31'd0, bus.ALU_vld}, 32'd1);
        check_flags("b2b1", 1'b1, 1'b1, 1'b0, 1'b1);
        bus.A = 32'd9; bus.B = 32'd10; bus.ALU_sel = 4'd10;
        step();
        check("b2b2.out", bus.ALU_out, 32'd3);
        check("b2b2.vld", {31'd0, bus.ALU_vld}, 32'd1);
        check_flags("b2b2", 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while a result is pending discards it.
        bus.ALU_en = 1'b1; bus.ALU_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0; bus.ALU_en = 1'b0;
        check("rst2.out", bus.ALU_out, 32'd0);
        check("rst2.vld", {31'd0, bus.ALU_vld}, 32'd0);
        check_flags("rst2", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
